// File: rtl/lz77_pkg.sv
// Shared sizes, FSM states and token layout for the LZ77 search sequencer.
package lz77_pkg;

    localparam int SB_BYTES = 512;
    localparam int LA_BYTES = 16;
    localparam int MAX_LEN  = 15;
    localparam logic [9:0] SB_FULL = 10'(SB_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        SETTLE,
        EVAL,
        EMIT,
        SHIFT
    } lz_state_t;

    typedef struct packed {
        logic [10:0] offset;
        logic [4:0]  len;
        logic [7:0]  char;
    } lz_token_t;

endpackage

// File: rtl/lz77_search_ctrl_window.sv
// Search-window and look-ahead shift registers with their occupancy counters.
module lz77_window
    import lz77_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   shift,
    input  logic                   push_sb,
    input  logic [7:0]             insert,
    input  logic                   la_inc,
    input  logic                   la_dec,
    output logic [SB_BYTES*8-1:0]  sb_data,
    output logic [LA_BYTES*8-1:0]  la_data,
    output logic [9:0]             sb_count,
    output logic [4:0]             la_count
);

    // Window contents survive a new start; only the occupancy counters restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_data  <= '0;
            la_data  <= '0;
            sb_count <= '0;
            la_count <= '0;
        end else if (clear) begin
            sb_count <= '0;
            la_count <= '0;
        end else if (shift) begin
            la_data <= {la_data[LA_BYTES*8-9:0], insert};
            if (push_sb) begin
                sb_data <= {sb_data[SB_BYTES*8-9:0], la_data[LA_BYTES*8-1 -: 8]};
                if (sb_count != SB_FULL) begin
                    sb_count <= sb_count + 10'd1;
                end
            end
            if (la_inc) begin
                la_count <= la_count + 5'd1;
            end else if (la_dec) begin
                la_count <= la_count - 5'd1;
            end
        end
    end

endmodule

// File: rtl/lz77_search_ctrl.sv
// Sequencer around the LZ77 search engine: fills windows, qualifies matches,
// emits (offset, length, next-char) tokens and slides the windows.
module lz77_search_ctrl
    import lz77_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [SB_BYTES*8-1:0]  sb_data_o,
    output logic [LA_BYTES*8-1:0]  la_data_o,
    input  logic [4:0]             srch_len_i,
    input  logic [10:0]            srch_idx_i,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [10:0]            out_offset,
    output logic [4:0]             out_len,
    output logic [7:0]             out_char,
    output logic                   busy,
    output logic                   done
);

    lz_state_t  state;
    logic       ended;
    logic [4:0] fill_cnt;
    logic [4:0] shift_rem;
    lz_token_t  tok_q;

    logic [9:0] sb_count;
    logic [4:0] la_count;
    logic       in_hs;
    logic       win_clear;
    logic       win_shift;
    logic       win_push;
    logic       la_inc;
    logic       la_dec;
    logic [7:0] win_insert;

    logic [4:0] la_room;
    logic [4:0] eval_len;
    logic [3:0] char_pos;
    lz_token_t  eval_tok;

    assign in_ready   = ((state == FILL) || (state == SHIFT)) && !ended;
    assign in_hs      = in_valid && in_ready;
    assign out_offset = tok_q.offset;
    assign out_len    = tok_q.len;
    assign out_char   = tok_q.char;

    // Once the stream has ended, the windows keep sliding with zero padding.
    always_comb begin
        win_clear  = (state == IDLE) && start;
        win_shift  = 1'b0;
        win_push   = 1'b0;
        la_inc     = 1'b0;
        la_dec     = 1'b0;
        win_insert = ended ? 8'h00 : in_data;
        case (state)
            FILL: begin
                win_shift = ended || in_hs;
                la_inc    = in_hs;
            end
            SHIFT: begin
                win_shift = ended || in_hs;
                win_push  = 1'b1;
                la_dec    = ended;
            end
            default: begin
            end
        endcase
    end

    lz77_window u_window (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (win_clear),
        .shift    (win_shift),
        .push_sb  (win_push),
        .insert   (win_insert),
        .la_inc   (la_inc),
        .la_dec   (la_dec),
        .sb_data  (sb_data_o),
        .la_data  (la_data_o),
        .sb_count (sb_count),
        .la_count (la_count)
    );

    // A match may not reach past the last valid look-ahead byte, since the
    // following byte must still be emitted as the token's next-char.
    always_comb begin
        la_room  = la_count - 5'd1;
        eval_len = (srch_len_i < la_room) ? srch_len_i : la_room;
        if (eval_len > 5'(MAX_LEN)) begin
            eval_len = 5'(MAX_LEN);
        end
        if ((srch_len_i == 5'd0) || (srch_idx_i >= {1'b0, sb_count})) begin
            eval_len = 5'd0;
        end
        char_pos        = 4'(MAX_LEN) - eval_len[3:0];
        eval_tok.len    = eval_len;
        eval_tok.offset = (eval_len == 5'd0) ? 11'd0 : srch_idx_i;
        eval_tok.char   = la_data_o[{char_pos, 3'b000} +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ended     <= 1'b0;
            fill_cnt  <= '0;
            shift_rem <= '0;
            tok_q     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (in_hs && in_last) begin
                ended <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        ended    <= 1'b0;
                        fill_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= FILL;
                    end
                end
                FILL: begin
                    if (win_shift) begin
                        fill_cnt <= fill_cnt + 5'd1;
                        if (fill_cnt == 5'(LA_BYTES - 1)) begin
                            state <= SETTLE;
                        end
                    end
                end
                SETTLE: state <= EVAL;
                EVAL: begin
                    tok_q     <= eval_tok;
                    shift_rem <= eval_len + 5'd1;
                    out_valid <= 1'b1;
                    state     <= EMIT;
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        // While input is still arriving the look-ahead is full,
                        // so only an ended stream can be fully consumed.
                        if (ended && (la_count == shift_rem)) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (win_shift) begin
                        shift_rem <= shift_rem - 5'd1;
                        if (shift_rem == 5'd1) begin
                            state <= SETTLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lz77_search_ctrl.sv
// Self-checking bench for lz77_search_ctrl: forced search stub plus a
// behavioural longest-match search, checked against a stream-position model.
`timescale 1ns/1ps
module tb_lz77_search_ctrl;
    import lz77_pkg::*;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic           in_valid;
    logic [7:0]     in_data;
    logic           in_last;
    logic           in_ready;
    logic [4095:0]  sb_data_o;
    logic [127:0]   la_data_o;
    logic [4:0]     srch_len_i;
    logic [10:0]    srch_idx_i;
    logic           out_valid;
    logic           out_ready;
    logic [10:0]    out_offset;
    logic [4:0]     out_len;
    logic [7:0]     out_char;
    logic           busy;
    logic           done;

    int total = 0;
    int bad   = 0;

    logic [7:0] stream    [0:511];
    int         force_len [0:511];
    int         force_idx [0:511];
    logic       use_model;
    int         tok_idx;
    logic [4:0] m_len;
    logic [10:0] m_idx;

    always #5 clk = ~clk;

    assign srch_len_i = use_model ? m_len : 5'(force_len[tok_idx]);
    assign srch_idx_i = use_model ? m_idx : 11'(force_idx[tok_idx]);

    lz77_search_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .sb_data_o  (sb_data_o),
        .la_data_o  (la_data_o),
        .srch_len_i (srch_len_i),
        .srch_idx_i (srch_idx_i),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_offset (out_offset),
        .out_len    (out_len),
        .out_char   (out_char),
        .busy       (busy),
        .done       (done)
    );

    // Behavioural search engine: longest match of the look-ahead against the
    // search window, matches kept inside history, result registered.
    always @(posedge clk) begin
        int best_k;
        int best_l;
        int l;
        best_k = 0;
        best_l = 0;
        for (int k = 0; k < SB_BYTES; k++) begin
            l = 0;
            while ((l < LA_BYTES) && (l <= k) &&
                   (sb_data_o[8*(k-l) +: 8] == la_data_o[8*(LA_BYTES-1-l) +: 8]))
                l++;
            if (l > best_l) begin
                best_l = l;
                best_k = k;
            end
        end
        m_len <= 5'(best_l);
        m_idx <= 11'(best_k);
    end

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_reset_state(input string pfx);
        check_output({pfx, "_in_ready"},  in_ready, 0);
        check_output({pfx, "_out_valid"}, out_valid, 0);
        check_output({pfx, "_busy"},      busy, 0);
        check_output({pfx, "_done"},      done, 0);
        check_output({pfx, "_token"},     {out_offset, out_len, out_char}, 0);
        check_output({pfx, "_sb_ones"},   $countones(sb_data_o), 0);
        check_output({pfx, "_la_ones"},   $countones(la_data_o), 0);
    endtask

    task automatic clear_forces();
        for (int i = 0; i < 512; i++) begin
            force_len[i] = 0;
            force_idx[i] = 0;
        end
    endtask

    // Runs one stream; tokens are predicted from the stream position alone.
    task automatic apply_stimulus(input int n, input int abort_tok, input int stall_pct);
        int fed, pos, toks, cycles, mism, la_cnt, sb_cnt, exp_len, exp_off;
        int dec_len, src, match_toks;
        logic [7:0] dec [0:511];
        logic [7:0] exp_b;
        logic prev_ov, prev_or, prev_iv, prev_ir, seen_done, abort_pending, aborted;
        logic [23:0] prev_tok;
        logic [4095:0] prev_sb;
        logic [127:0] prev_la;
        fed = 0; pos = 0; toks = 0; cycles = 0; dec_len = 0; match_toks = 0;
        prev_ov = 0; prev_or = 0; prev_iv = 0; prev_ir = 0;
        seen_done = 0; abort_pending = 0; aborted = 0;
        prev_tok = '0; prev_sb = '0; prev_la = '0;
        tok_idx = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_output("busy_after_start", busy, 1);
        while (!seen_done && (cycles < 20000)) begin
            if (prev_iv && prev_ir) fed++;
            if (abort_pending && prev_ov && prev_or) begin
                rst_n = 1'b0;
                #1;
                check_reset_state("abort");
                aborted = 1;
                break;
            end
            if (prev_ov && !prev_or)
                check_output("token_stable", {out_valid, out_offset, out_len, out_char},
                             {1'b1, prev_tok});
            if (prev_ir && !prev_iv)
                check_output("win_frozen", {sb_data_o != prev_sb, la_data_o != prev_la}, 0);
            if (out_valid && !prev_ov) begin
                la_cnt = (n - pos > 16) ? 16 : n - pos;
                sb_cnt = (pos > 512) ? 512 : pos;
                check_output("busy_hi", busy, 1);
                check_output("fed_at_token", fed, (n < pos + 16) ? n : pos + 16);
                mism = 0;
                for (int j = 0; j < 16; j++) begin
                    exp_b = (pos + j < n) ? stream[pos + j] : 8'h00;
                    if (la_data_o[8*(15-j) +: 8] !== exp_b) mism++;
                end
                check_output("la_window", mism, 0);
                mism = 0;
                for (int k = 0; k < pos && k < 512; k++)
                    if (sb_data_o[8*k +: 8] !== stream[pos-1-k]) mism++;
                check_output("sb_window", mism, 0);
                if (use_model) begin
                    check_output("offset_in_history", (out_len != 0) && (out_offset >= sb_cnt), 0);
                    for (int j = 0; j < out_len; j++) begin
                        src = dec_len - int'(out_offset) - 1;
                        if (dec_len < 512) dec[dec_len] = (src >= 0) ? dec[src] : 8'hxx;
                        dec_len++;
                    end
                    if (dec_len < 512) dec[dec_len] = out_char;
                    dec_len++;
                    if (out_len != 0) match_toks++;
                    pos += int'(out_len) + 1;
                end else begin
                    exp_len = force_len[toks];
                    if ((exp_len == 0) || (force_idx[toks] >= sb_cnt)) begin
                        exp_len = 0;
                    end else begin
                        if (exp_len > la_cnt - 1) exp_len = la_cnt - 1;
                        if (exp_len > MAX_LEN) exp_len = MAX_LEN;
                    end
                    exp_off = (exp_len == 0) ? 0 : force_idx[toks];
                    check_output($sformatf("token%0d", toks), {out_offset, out_len, out_char},
                                 {11'(exp_off), 5'(exp_len), stream[pos + exp_len]});
                    pos += exp_len + 1;
                end
                toks++;
                tok_idx = toks;
                if ((abort_tok != 0) && (toks == abort_tok)) abort_pending = 1;
            end
            if (done) begin
                seen_done = 1;
                check_output("done_all_consumed", pos, n);
                check_output("busy_low_at_done", busy, 0);
            end
            in_valid  = (($urandom_range(99) >= stall_pct) && (fed < n)) ? 1'b1 : 1'b0;
            in_data   = (fed < n) ? stream[fed] : 8'h00;
            in_last   = (fed == n - 1) ? 1'b1 : 1'b0;
            out_ready = ($urandom_range(99) >= stall_pct) ? 1'b1 : 1'b0;
            prev_iv = in_valid; prev_ir = in_ready;
            prev_ov = out_valid; prev_or = out_ready;
            prev_tok = {out_offset, out_len, out_char};
            prev_sb = sb_data_o; prev_la = la_data_o;
            cycles++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!aborted) begin
            check_output("stream_completed", seen_done, 1);
            check_output("done_is_pulse", done, 0);
            if (use_model) begin
                mism = 0;
                for (int i = 0; i < n && i < dec_len && i < 512; i++)
                    if (dec[i] !== stream[i]) mism++;
                check_output("decode_len", dec_len, n);
                check_output("decode_bytes", mism, 0);
                check_output("has_matches", match_toks > 0, 1);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        in_last = 1'b0; out_ready = 1'b0; use_model = 1'b0; tok_idx = 0;
        clear_forces();
        #23;
        check_reset_state("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_reset_state("idle");

        $display("[TB] three-byte literal stream");
        stream[0] = 8'h41; stream[1] = 8'h42; stream[2] = 8'h43;
        apply_stimulus(3, 0, 0);

        $display("[TB] 40-byte stream with a forced match at token 30");
        for (int i = 0; i < 40; i++) stream[i] = 8'($urandom);
        force_idx[30] = 20; force_len[30] = 5;
        apply_stimulus(40, 0, 20);

        $display("[TB] 150-byte stream: out-of-history index, length clamp, stalls");
        clear_forces();
        for (int i = 0; i < 150; i++) stream[i] = 8'($urandom);
        force_idx[100] = 300; force_len[100] = 4;
        force_idx[101] = 50;  force_len[101] = 16;
        force_idx[102] = 7;   force_len[102] = 5;
        apply_stimulus(150, 0, 30);

        $display("[TB] behavioural search on repeated ab");
        clear_forces();
        use_model = 1'b1;
        for (int i = 0; i < 64; i++) stream[i] = (i % 2 == 1) ? 8'h62 : 8'h61;
        apply_stimulus(64, 0, 20);

        $display("[TB] behavioural search on small-alphabet random data");
        for (int i = 0; i < 100; i++) stream[i] = 8'h61 + 8'($urandom_range(2));
        apply_stimulus(100, 0, 25);

        $display("[TB] reset during SHIFT, then restart");
        use_model = 1'b0;
        for (int i = 0; i < 60; i++) stream[i] = 8'($urandom);
        apply_stimulus(60, 5, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 20; i++) stream[i] = 8'($urandom);
        force_idx[8] = 3; force_len[8] = 2;
        apply_stimulus(20, 0, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lz77_search_ctrl.md
# lz77_search_ctrl

Sequencer for the LZ77 `search` match engine. It accepts a byte stream and maintains the 512-byte search window and the 16-byte look-ahead window that feed `search`. Each cycle of operation it waits for the engine result, qualifies it against valid history, and emits one (offset, length, next-char) token. It then slides the windows by length+1 bytes and repeats until the stream is exhausted.

## Interface
- Parameters: none. Sizes are fixed by `search`: `SB_BYTES`=512, `LA_BYTES`=16 (package constants).
- Clock and reset are decided: one clock; reset is asynchronous and active-low.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle pulse that begins a stream; ignored while `busy`.
- `in_valid` in 1: input byte valid.
- `in_data` in 8: input byte.
- `in_last` in 1: qualifies the final byte of the stream.
- `in_ready` out 1: byte accepted when `in_valid && in_ready`.
- `sb_data_o` out 4096: search window to `search_buffer_w`; byte k at bits [8k+7:8k]; k=0 is the newest.
- `la_data_o` out 128: look-ahead to `look_ahead_buffer_w`; byte 15 is the next byte to encode, byte 0 the newest.
- `srch_len_i` in 5: `match_len` from `search`.
- `srch_idx_i` in 11: `SB_index` from `search` (registered inside `search`).
- `out_valid` out 1: token valid.
- `out_ready` in 1: token consumer ready.
- `out_offset` out 11: search-window index of the match start (byte k lies k+1 positions behind la[15]); 0 for literals.
- `out_len` out 5: match length, 0..15; 0 = literal.
- `out_char` out 8: byte following the match.
- `busy` out 1: high from accepted `start` until `done`.
- `done` out 1: one-cycle pulse after the last token handshakes.

## Operation
States: IDLE, FILL, SETTLE, EVAL, EMIT, SHIFT.
- **IDLE**: windows hold their contents. On `start`: clear `sb_count`, `la_count`, `ended`, `fill_cnt`; go to FILL.
- **FILL**: performs exactly 16 look-ahead shifts (la[i+1] <= la[i], la[0] <= byte). The byte shifted out of la[15] is discarded and does not enter the search window.
  - When `!ended`, `in_ready`=1. A shift occurs only on handshake; it inserts `in_data` and increments `la_count`. Handshake with `in_last` sets `ended`.
  - When `ended`, a shift occurs every cycle and inserts 0x00.
  - After shift 16, go to SETTLE. A stream shorter than 16 bytes therefore ends up aligned with its first byte at la[15].
- **SETTLE**: 1 cycle with windows static, so `search` registers `SB_index`. Then go to EVAL.
- **EVAL**: compute the token and register it.
  - Literal when `srch_len_i`==0 or `srch_idx_i >= sb_count`: offset=0, len=0.
  - Otherwise: offset=`srch_idx_i`, len=min(`srch_len_i`, `la_count`-1), saturated to 15. If len becomes 0, the token is a literal.
  - `out_char` = la[15-len].
  - Load `shift_rem` = len+1; go to EMIT.
- **EMIT**: `out_valid`=1; token fields stay stable until `out_ready`. After the handshake:
  - if `la_count` == `shift_rem`, the stream is fully consumed: pulse `done` and go to IDLE;
  - otherwise go to SHIFT.
- **SHIFT**: each shift pushes la[15] into sb[0] (sb[k+1] <= sb[k], sb[511] dropped) and shifts the look-ahead up one.
  - `sb_count` increments and saturates at 512.
  - If `!ended`: a shift occurs only on input handshake, inserting `in_data`, and `la_count` is unchanged. With `in_valid` low there is no shift (stall).
  - If `ended`: a shift occurs every cycle, inserting 0x00, and `la_count` decrements.
  - When `shift_rem` reaches 0, go to SETTLE.
- Counter widths: `sb_count` 10 bits (0..512), `la_count` 5 bits, `shift_rem` 5 bits, `fill_cnt` 5 bits.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_offset`/`out_len`/`out_char`=0, `busy`=0, `done`=0, `sb_data_o`=0, `la_data_o`=0, FSM=IDLE.
- `in_ready` is combinational from state and `ended` only; it never depends on `in_valid`.
- Latency: last window change → SETTLE (1) → EVAL (1) → `out_valid` in the next cycle. Minimum token period is len+4 cycles.
- `done` is asserted in the cycle after the final EMIT handshake, and `busy` drops in the same cycle.
- Reset mid-operation aborts immediately. There is no partial token, and the next `start` begins cleanly.
- `in_last` with `in_valid` low has no effect.

## Structure
- Package `lz77_pkg` holds:
  - `SB_BYTES`, `LA_BYTES`, `MAX_LEN`=15;
  - state enum `lz_state_t`;
  - struct `lz_token_t` {offset[10:0], len[4:0], char[7:0]}.
- One sub-module, `lz77_window`: the search and look-ahead shift registers, plus the `push_sb` / `insert` controls and both counters.
- The FSM lives in the top level. `search` is instantiated beside this block, not inside it.

## Test plan
The bench uses a behavioural `search` stub with forced outputs, except in scenario 6.
1. Reset, then idle 5 cycles → `in_ready`=0, `out_valid`=0, `busy`=0, all data outputs 0.
2. `start`, then bytes 0x41, 0x42, 0x43 with `in_last` on 0x43, stub len=0 → tokens (0,0,0x41), (0,0,0x42), (0,0,0x43), then a `done` pulse.
3. 40-byte stream; after 30 tokens, stub idx=20, len=5 → token (20, 5, la[10]), followed by exactly 6 shift handshakes before the next token.
4. Stub idx=300 with `sb_count`=100 → literal token (0, 0, la[15]). Stub len=16 with `la_count`=16 → len=15.
5. `out_ready` held low for 3 cycles during EMIT → token fields stable, no shift. `in_valid` low for 2 cycles in SHIFT → windows frozen.
6. Real `search` instance with a 64-byte stream of "ab" repeated → decoding the emitted tokens reproduces the input byte-exact. Assert `rst_n` mid-SHIFT → all outputs at reset values, and a following `start` works.
